// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: prefix parsing, held-key stack with
// last-pressed priority, typematic suppression and event strobes.
module ps2_key_tracker #(
  parameter int          DEPTH   = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iFlag,
  input  logic [7:0] iData,
  output logic [7:0] oKeyCode,
  output logic       oExtended,
  output logic       oKeyValid,
  output logic       oPressStrobe,
  output logic       oReleaseStrobe,
  output logic [3:0] oHeldCount
);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXTBRK
  } state_t;

  state_t      state;
  logic [15:0] tmo_cnt;

  logic        op_valid;
  logic        op_make;
  logic [8:0]  op_key;

  logic [8:0]  stack     [DEPTH];
  logic [8:0]  stack_nxt [DEPTH];
  logic [3:0]  count;
  logic [3:0]  count_nxt;
  logic        press_nxt;
  logic        release_nxt;
  logic        hit;
  logic [3:0]  hit_idx;

  logic        is_e0;
  logic        is_f0;
  logic        ignore;
  logic        expire;

  assign is_e0  = (iData == 8'hE0);
  assign is_f0  = (iData == 8'hF0);
  assign ignore = (iData == 8'h00) || (iData == 8'hAA) ||
                  (iData == 8'hEE) || (iData == 8'hFA) ||
                  (iData == 8'hFE) || (iData == 8'hFF);
  assign expire = (tmo_cnt == TIMEOUT - 16'd1);

  // Prefix FSM: turns the byte stream into one make/break op per key event
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state    <= IDLE;
      tmo_cnt  <= 16'd0;
      op_valid <= 1'b0;
      op_make  <= 1'b0;
      op_key   <= 9'h000;
    end else begin
      op_valid <= 1'b0;
      if (iFlag) begin
        tmo_cnt <= 16'd0;
        case (state)
          IDLE: begin
            if (is_e0) begin
              state <= EXT;
            end else if (is_f0) begin
              state <= BRK;
            end else if (!ignore) begin
              op_valid <= 1'b1;
              op_make  <= 1'b1;
              op_key   <= {1'b0, iData};
            end
          end
          EXT: begin
            if (is_f0) begin
              state <= EXTBRK;
            end else if (!is_e0) begin
              op_valid <= 1'b1;
              op_make  <= 1'b1;
              op_key   <= {1'b1, iData};
              state    <= IDLE;
            end
          end
          BRK, EXTBRK: begin
            if (!is_e0 && !is_f0) begin
              op_valid <= 1'b1;
              op_make  <= 1'b0;
              op_key   <= {state == EXTBRK, iData};
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (expire) begin
          state   <= IDLE;
          tmo_cnt <= 16'd0;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end
    end
  end

  // Stack update: push-to-top on new make, compact on break
  always_comb begin
    hit         = 1'b0;
    hit_idx     = 4'd0;
    stack_nxt   = stack;
    count_nxt   = count;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && i < int'(count) && stack[i] == op_key) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
    if (op_valid && op_make && !hit) begin
      stack_nxt[0] = op_key;
      for (int i = 1; i < DEPTH; i++) begin
        stack_nxt[i] = stack[i-1];
      end
      if (int'(count) < DEPTH) begin
        count_nxt = count + 4'd1;
      end
      press_nxt = 1'b1;
    end else if (op_valid && !op_make && hit) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(hit_idx)) begin
          stack_nxt[i] = stack[i+1];
        end
      end
      stack_nxt[DEPTH-1] = 9'h000;
      count_nxt   = count - 4'd1;
      release_nxt = 1'b1;
    end
  end

  // Registered stack and outputs; unused entries held at zero
  always_ff @(posedge iClk) begin
    if (iReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= 9'h000;
      end
      count          <= 4'd0;
      oKeyValid      <= 1'b0;
      oPressStrobe   <= 1'b0;
      oReleaseStrobe <= 1'b0;
    end else begin
      stack          <= stack_nxt;
      count          <= count_nxt;
      oKeyValid      <= (count_nxt != 4'd0);
      oPressStrobe   <= press_nxt;
      oReleaseStrobe <= release_nxt;
    end
  end

  assign oKeyCode   = stack[0][7:0];
  assign oExtended  = stack[0][8];
  assign oHeldCount = count;

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sits between the PS/2 byte receiver (one-cycle strobe plus 8-bit byte) and the scan-code decoder/controller path of the piano.
- Parses set-2 prefix bytes (E0 extended, F0 break) and tracks physically held keys in a last-pressed-priority stack.
- Suppresses typematic repeats and presents a clean "current key" plus one-cycle press/release event strobes.
- Downstream note selection therefore follows the most recently pressed key still held, and falls back to earlier held keys when it is released.

Parameters:
- DEPTH, 4, number of simultaneously held keys tracked (2..8).
- TIMEOUT, 16'd50000, iClk cycles allowed between a prefix byte and its completing byte before the prefix is discarded.

Ports:
- iClk  input  1  system clock; all logic is on the rising edge.
- iReset  input  1  synchronous reset, active-high.
- iFlag  input  1  one-cycle strobe; iData is valid in that cycle.
- iData  input  8  received PS/2 byte.
- oKeyCode  output  8  scan code of the top-of-stack held key; 8'h00 when no key is held.
- oExtended  output  1  top-of-stack key was E0-prefixed; 0 when no key is held.
- oKeyValid  output  1  at least one key is held.
- oPressStrobe  output  1  one-cycle pulse when a new key is pushed.
- oReleaseStrobe  output  1  one-cycle pulse when a held key is removed.
- oHeldCount  output  4  number of valid stack entries (0..DEPTH).

Behaviour:
- Reset (synchronous, iReset=1 at an edge):
  - FSM returns to IDLE; the stack is cleared; the timeout counter is zeroed.
  - All outputs are 0. Reset has priority over a coincident iFlag.
- Stack entry: 9 bits {ext, code}; entries compare equal only if both ext and code match. Entry 0 is the top of stack.
- FSM states and transitions:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make of {0, byte}.
  - EXT: F0 -> EXTBRK; E0 -> stays in EXT; any other byte is a make of {1, byte}, then -> IDLE.
  - BRK: any byte other than E0/F0 is a break of {0, byte}, then -> IDLE; E0/F0 -> IDLE with no action.
  - EXTBRK: any byte other than E0/F0 is a break of {1, byte}, then -> IDLE; E0/F0 -> IDLE with no action.
- Ignored bytes: in IDLE, 00, AA, EE, FA, FE and FF produce no action and no state change.
- Make handling:
  - Key already in the stack (typematic repeat): no change and no strobe, including when it is not on top.
  - Key absent and stack not full: shift the stack down, write the key at entry 0, increment the count, pulse oPressStrobe.
  - Key absent and stack full: shift down and drop the oldest (bottom) entry; the count stays at DEPTH; pulse oPressStrobe.
- Break handling:
  - Key present at index k: remove it, compact entries k+1..count-1 up by one, decrement the count, pulse oReleaseStrobe.
  - Key absent: no action and no strobe.
- Latency: the byte with iFlag at edge N is reflected in all outputs after edge N+1. Outputs are registered. Strobes are high for exactly one cycle.
- Timeout:
  - The counter runs only while in EXT, BRK or EXTBRK, and clears on every iFlag.
  - When it reaches TIMEOUT-1 with no iFlag, the FSM returns to IDLE and the pending prefix is discarded; stack and outputs are unchanged.
  - An iFlag in the same cycle as expiry is processed normally; the byte wins.
- Top-of-stack outputs: oKeyCode/oExtended always reflect entry 0 when count>0. After a release of the top entry they show the new entry 0 in the same update cycle.
- Bytes are processed strictly in arrival order; iFlag pulses are at least 2 cycles apart (guaranteed upstream).

Test Plan:
- Reset, then bytes 1C -> oKeyCode=1C, oExtended=0, oKeyValid=1, oHeldCount=1, oPressStrobe high for 1 cycle exactly 1 cycle after the byte.
- 1C, 1C, 1C (typematic repeat) -> single press strobe, oHeldCount=1; then F0 1C -> oReleaseStrobe pulse, oKeyValid=0, oKeyCode=00.
- 1C, 1B, 23, then F0 1B (middle) -> top stays 23, count=2; then F0 23 -> top becomes 1C, count=1.
- E0 75, then 75 -> two distinct entries; top is {0,75}, count=2; E0 F0 75 removes only the extended entry, count=1, top {0,75}.
- With DEPTH=4, press 15,1D,24,2D,2C -> count stays 4, five press strobes, 15 is dropped; F0 15 -> no strobe.
- F0 followed by no byte for TIMEOUT cycles, then 1C -> treated as a make (count=1). Separately, iReset asserted mid E0-F0 sequence -> all outputs 0; a following 75 is a plain make {0,75}.
